// File: rtl/timebase_pulse_gen.sv
// -----------------------------------------------------------------------------
// timebase_pulse_gen
//
// Programmable timebase for the step, display and sequencing logic. A period
// counter runs from 0 to div_act and wraps. div_act + 1 is the period in CLK
// cycles. Three output behaviours are selected by MODE:
//   00 : CP is a square wave that toggles at every terminal count.
//   01 : TICK is a one-cycle pulse after every terminal count (11 acts as 01).
//   10 : a START strobe launches a burst of BURST_N ticks. BUSY stays high
//        while the burst runs.
// A new divisor is staged in a shadow register. It becomes active only at a
// period boundary, or at once while the counter is stopped. This means a
// running period is never cut short or stretched.
//
// Ports
//   CLK        in   system clock; all state changes on the rising edge
//   RST        in   asynchronous reset, active high
//   EN         in   count enable; low freezes the counter, CP and the burst
//   MODE[1:0]  in   00 square, 01 tick, 10 burst, 11 same as 01
//   DIV        in   requested divisor (period = DIV + 1 cycles)
//   DIV_LD     in   one-cycle strobe: capture DIV into the shadow register
//   DIV_ACK    out  one-cycle pulse: the shadow divisor became active
//   BURST_N    in   number of ticks in a burst
//   START      in   one-cycle strobe: start a burst (mode 10, idle only)
//   CP         out  square wave, meaningful in mode 00 only
//   TICK       out  one-cycle pulse per terminal count (modes 01, 10)
//   BUSY       out  burst in progress
//   DBG_STATE  out  burst FSM state (0 idle, 1 burst)
//
// Divisor handshake: DIV_LD acts as the request, and the block accepts it
// without back-pressure. DIV_ACK is the matching completion. It pulses exactly
// once, in the cycle after the divisor becomes active. Several DIV_LD strobes
// that arrive before activation merge into one request; the last DIV wins and
// only one DIV_ACK follows.
// -----------------------------------------------------------------------------
module timebase_pulse_gen #(
  parameter int          CNT_W   = 16,
  parameter int          BURST_W = 8,
  parameter int unsigned DIV_RST = 7324
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic [1:0]         MODE,
  input  logic [CNT_W-1:0]   DIV,
  input  logic               DIV_LD,
  output logic               DIV_ACK,
  input  logic [BURST_W-1:0] BURST_N,
  input  logic               START,
  output logic               CP,
  output logic               TICK,
  output logic               BUSY,
  output logic               DBG_STATE
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   div_act;
  logic [CNT_W-1:0]   pend;
  logic               pend_v;
  logic [BURST_W-1:0] burst_rem;

  logic [1:0] mode_eff;
  logic       is_sq;
  logic       is_burst;
  logic       run;
  logic       tc;
  logic       apply_ok;
  logic       bypass;
  logic       apply_pend;
  logic       stage_ld;
  logic       burst_go;

  // Mode 11 is folded onto the tick mode so the rest of the logic sees only
  // three modes.
  assign mode_eff = (MODE == 2'b11) ? 2'b01 : MODE;
  assign is_sq    = (mode_eff == 2'b00);
  assign is_burst = (mode_eff == 2'b10);

  // In burst mode the counter runs only while a burst is active.
  assign run = EN & (~is_burst | BUSY);
  assign tc  = run & (count == div_act);

  // A divisor may be switched only at a period boundary or while the counter
  // is stopped. Either way, no running period changes length.
  assign apply_ok   = tc | ~run;
  // A load that arrives when switching is allowed goes straight to div_act.
  // It also replaces any older staged value, so only one ack is issued.
  assign bypass     = DIV_LD & apply_ok;
  assign apply_pend = pend_v & apply_ok & ~DIV_LD;
  assign stage_ld   = DIV_LD & ~apply_ok;

  assign burst_go = is_burst & (state == S_IDLE) & START & (BURST_N != '0);

  assign DBG_STATE = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      count     <= '0;
      div_act   <= CNT_W'(DIV_RST);
      pend      <= '0;
      pend_v    <= 1'b0;
      burst_rem <= '0;
      CP        <= 1'b0;
      TICK      <= 1'b0;
      DIV_ACK   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      // Pulse outputs. tc already includes run, so TICK is 0 while frozen.
      TICK    <= tc & ~is_sq;
      DIV_ACK <= bypass | apply_pend;

      // Square wave: it holds while EN is low and is forced low outside mode 00.
      if (!is_sq) begin
        CP <= 1'b0;
      end else if (tc) begin
        CP <= ~CP;
      end

      // Shadow divisor and active divisor.
      if (stage_ld) begin
        pend   <= DIV;
        pend_v <= 1'b1;
      end else if (bypass) begin
        div_act <= DIV;
        pend_v  <= 1'b0;
      end else if (apply_pend) begin
        div_act <= pend;
        pend_v  <= 1'b0;
      end

      // Period counter. A new divisor or a new burst always starts from 0.
      if (burst_go || bypass || apply_pend || tc) begin
        count <= '0;
      end else if (run) begin
        count <= count + CNT_W'(1);
      end

      // Burst FSM
      case (state)
        S_IDLE: begin
          if (burst_go) begin
            state     <= S_BURST;
            BUSY      <= 1'b1;
            burst_rem <= BURST_N;
          end
        end
        S_BURST: begin
          if (!is_burst) begin
            // Leaving burst mode aborts the burst. The ticks already issued
            // stay valid.
            state     <= S_IDLE;
            BUSY      <= 1'b0;
            burst_rem <= '0;
          end else if (tc) begin
            burst_rem <= burst_rem - BURST_W'(1);
            if (burst_rem == BURST_W'(1)) begin
              state <= S_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timebase_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_timebase_pulse_gen
//
// Directed bench for timebase_pulse_gen, built with DIV_RST = 3.
// The inputs for a cycle are driven 1 time unit after a rising edge. Outputs
// are sampled 1 time unit after the next rising edge, so every sample shows
// the state that edge produced. Cycle numbers of TICK and DIV_ACK pulses are
// collected into queues and compared with hand-computed cycle numbers held in
// exp_q.
// -----------------------------------------------------------------------------
module tb_timebase_pulse_gen;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;

  // ---------------- clock / reset ----------------
  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   div;
  logic               div_ld;
  logic               div_ack;
  logic [BURST_W-1:0] burst_n;
  logic               start;
  logic               cp;
  logic               tick;
  logic               busy;
  logic               dbg_state;

  always #5 clk = ~clk;

  timebase_pulse_gen #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W),
    .DIV_RST (3)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .EN        (en),
    .MODE      (mode),
    .DIV       (div),
    .DIV_LD    (div_ld),
    .DIV_ACK   (div_ack),
    .BURST_N   (burst_n),
    .START     (start),
    .CP        (cp),
    .TICK      (tick),
    .BUSY      (busy),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0;

  logic [15:0] exp_q[$];
  logic [15:0] got_tick_q[$];
  logic [15:0] got_ack_q[$];

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       cp;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (tick === 1'b1)    got_tick_q.push_back(16'(cyc));
    if (div_ack === 1'b1) got_ack_q.push_back(16'(cyc));
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_tick_q.delete();
    got_ack_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 2'b00; div = '0; div_ld = 1'b0;
    burst_n = '0; start = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Compare the observed tick cycles with exp_q, one entry at a time.
  task automatic chk_ticks(input string name);
    chk({name, "_count"}, 32'(got_tick_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got_tick_q.size()) chk({name, "_at"}, 32'(got_tick_q[i]), 32'(exp_q[i]));
      else                       chk({name, "_at"}, 32'hFFFF, 32'(exp_q[i]));
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [1:0] m,
                     input logic c, input logic t, input int n);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.cp = c; v.tick = t;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; div = '0; div_ld = 1'b0;
    burst_n = '0; start = 1'b0;

    // Table: reset, square wave at div 3, EN freeze, then switch to mode 01/11.
    add(1, 1, 2'd0, 0, 0, 1);   // row 0: reset
    add(0, 1, 2'd0, 0, 0, 3);   // 1-3
    add(0, 1, 2'd0, 1, 0, 4);   // 4-7  first rise after 4 cycles
    add(0, 1, 2'd0, 0, 0, 4);   // 8-11
    add(0, 1, 2'd0, 1, 0, 1);   // 12
    add(0, 0, 2'd0, 1, 0, 2);   // 13-14 EN low: CP and count hold
    add(0, 1, 2'd0, 1, 0, 3);   // 15-17
    add(0, 1, 2'd0, 0, 0, 4);   // 18-21
    add(0, 1, 2'd0, 1, 0, 1);   // 22
    add(0, 1, 2'd1, 0, 0, 2);   // 23-24 leaving mode 00 clears CP
    add(0, 1, 2'd3, 0, 0, 1);   // 25    mode 11 behaves as 01
    add(0, 1, 2'd3, 0, 1, 1);   // 26    tc at count 3
    add(0, 1, 2'd3, 0, 0, 1);   // 27

    foreach (vecs[i]) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      step();
      chk($sformatf("vec%0d_cp", i),   32'(cp),      32'(vecs[i].cp));
      chk($sformatf("vec%0d_tick", i), 32'(tick),    32'(vecs[i].tick));
      chk($sformatf("vec%0d_busy", i), 32'(busy),    32'(0));
      chk($sformatf("vec%0d_ack", i),  32'(div_ack), 32'(0));
    end

    // Load while running: the period in progress ends on time. Two loads merge.
    do_reset();
    mode = 2'b01; en = 1'b0; div = 16'd4; div_ld = 1'b1;
    step();
    chk("ld4_ack", 32'(div_ack), 32'(1));
    div_ld = 1'b0;
    step();
    chk("ld4_ack_gone", 32'(div_ack), 32'(0));
    clear_q();
    t0 = cyc;
    en = 1'b1;
    step();                                  // count 0
    div = 16'd7; div_ld = 1'b1; step();      // count 1, staged
    div = 16'd9; step();                     // count 2, overwrite
    div_ld = 1'b0;
    repeat (24) step();
    exp_q.push_back(16'(t0 + 5));
    exp_q.push_back(16'(t0 + 15));
    exp_q.push_back(16'(t0 + 25));
    chk_ticks("ld9_tick");
    chk("ld9_ack_n", 32'(got_ack_q.size()), 32'(1));
    if (got_ack_q.size() > 0) chk("ld9_ack_at", 32'(got_ack_q[0]), 32'(t0 + 5));

    // Load of divisor 0 while frozen, then a tick every cycle.
    en = 1'b0; div = 16'd0; div_ld = 1'b1;
    step();
    chk("ld0_ack", 32'(div_ack), 32'(1));
    div_ld = 1'b0;
    step();
    chk("ld0_ack_gone", 32'(div_ack), 32'(0));
    chk("ld0_frozen_tick", 32'(tick), 32'(0));
    clear_q();
    t0 = cyc;
    en = 1'b1;
    repeat (6) step();
    for (int k = 1; k <= 6; k++) exp_q.push_back(16'(t0 + k));
    chk_ticks("div0_tick");

    // Burst of 3 at div 2, with a START inside the burst that is ignored.
    do_reset();
    mode = 2'b10; en = 1'b1; div = 16'd2; div_ld = 1'b1;
    step();
    chk("bdiv_ack", 32'(div_ack), 32'(1));
    div_ld = 1'b0;
    clear_q();
    burst_n = 8'd3; start = 1'b1;
    step();
    t0 = cyc;
    start = 1'b0;
    chk("b3_busy_start", 32'(busy), 32'(1));
    chk("b3_state", 32'(dbg_state), 32'(1));
    repeat (3) step();
    start = 1'b1; step(); start = 1'b0;       // t0+4
    repeat (4) step();                        // t0+8
    chk("b3_busy_mid", 32'(busy), 32'(1));
    step();                                   // t0+9 last tick
    chk("b3_busy_end", 32'(busy), 32'(0));
    repeat (6) step();
    exp_q.push_back(16'(t0 + 3));
    exp_q.push_back(16'(t0 + 6));
    exp_q.push_back(16'(t0 + 9));
    chk_ticks("b3_tick");

    // START with BURST_N 0 is ignored; then a burst of 5 paused for 4 cycles.
    clear_q();
    burst_n = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    chk("b0_busy", 32'(busy), 32'(0));
    repeat (4) step();
    chk("b0_busy_later", 32'(busy), 32'(0));
    burst_n = 8'd5; start = 1'b1;
    step();
    t0 = cyc;
    start = 1'b0;
    chk("b5_busy_start", 32'(busy), 32'(1));
    repeat (6) step();                        // ticks t0+3, t0+6
    en = 1'b0;
    repeat (4) step();                        // paused t0+7..t0+10
    chk("b5_busy_pause", 32'(busy), 32'(1));
    en = 1'b1;
    repeat (9) step();                        // t0+19 last tick
    chk("b5_busy_end", 32'(busy), 32'(0));
    repeat (5) step();
    exp_q.push_back(16'(t0 + 3));
    exp_q.push_back(16'(t0 + 6));
    exp_q.push_back(16'(t0 + 13));
    exp_q.push_back(16'(t0 + 16));
    exp_q.push_back(16'(t0 + 19));
    chk_ticks("b5_tick");

    // Reset during a burst that has a load staged. The load is dropped.
    do_reset();
    mode = 2'b10; en = 1'b1; div = 16'd2; div_ld = 1'b1;
    step();
    div_ld = 1'b0;
    burst_n = 8'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();                        // tick at +3, count 1 at +5 start
    div = 16'd6; div_ld = 1'b1;
    step();                                   // staged, not a terminal cycle
    div_ld = 1'b0;
    chk("rst_pre_busy", 32'(busy), 32'(1));
    clear_q();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_tick", 32'(tick), 32'(0));
    chk("rst_cp", 32'(cp), 32'(0));
    chk("rst_ack", 32'(div_ack), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));
    step();
    rst = 1'b0;
    mode = 2'b01; en = 1'b1;
    clear_q();
    t0 = cyc;
    repeat (13) step();
    exp_q.push_back(16'(t0 + 4));
    exp_q.push_back(16'(t0 + 8));
    exp_q.push_back(16'(t0 + 12));
    chk_ticks("post_rst_tick");
    chk("post_rst_ack_n", 32'(got_ack_q.size()), 32'(0));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
